// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions for receiver and transmitter:
//                FSM state encoding, minimum bit divisor and a divisor clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame FSM states, common to uart_rx and uart_tx
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Smallest usable clk-per-bit count; smaller requests are raised to this
  localparam logic [7:0] MIN_DIV = 8'd4;

  // Effective divisor: max(div, MIN_DIV)
  function automatic logic [7:0] clamp_div(input logic [7:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : N-flop synchronizer for a single asynchronous bit. All
//                stages reset to 1 so an idle-high line stays idle across
//                reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the asynchronous input through the N-stage chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Synchronizes the serial line, detects a
//                falling start edge, verifies the start bit at mid-bit, then
//                samples 8 data bits LSB first and the stop bit at the end of
//                each bit period. Emits a one-cycle rx_done or frame_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic [7:0] DIV,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  uart_state_e state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rxs_dly_q;

  logic        rxs;
  logic        start_edge;
  logic        half_last;
  logic        bit_last;

  uart_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (uart_rxd),
    .q_o   (rxs)
  );

  // Delayed copy of the synchronized line for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_dly_q <= 1'b1;
    end else begin
      rxs_dly_q <= rxs;
    end
  end

  // Start edge needs a high-to-low transition, so a held break never restarts
  assign start_edge = ~rxs & rxs_dly_q;
  // Start bit is checked at its middle; the rest at the end of each period,
  // which lands every later sample in the middle of its bit.
  assign half_last  = (count_q == ((div_q >> 1) - 8'd1));
  assign bit_last   = (count_q == (div_q - 8'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = START;
      START:   if (half_last) state_d = rxs ? IDLE : RECV;
      RECV:    if (bit_last && (bit_cnt_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and pulse next values, driven by the current state
  always_comb begin
    count_d   = count_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_d     = div_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = 8'd0;
        // Divisor is frozen here so DIV changes mid-frame are ignored
        if (start_edge) div_d = clamp_div(DIV);
      end
      START: begin
        if (half_last) begin
          count_d = 8'd0;
          if (!rxs) bit_cnt_d = 3'd0;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      RECV: begin
        if (bit_last) begin
          count_d           = 8'd0;
          shift_d[bit_cnt_q] = rxs;
          bit_cnt_d         = bit_cnt_q + 3'd1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_last) begin
          count_d = 8'd0;
          if (rxs) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      default: count_d = 8'd0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      div_q     <= MIN_DIV;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Outputs
  always_comb begin
    rx_busy   = (state_q != IDLE);
    rx_data   = data_q;
    rx_done   = done_q;
    frame_err = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed testbench for uart_rx: table of serial frames plus
//                hand-written timing, glitch, break, back-to-back, mid-frame
//                DIV change and reset-abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] DIV;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd  (uart_rxd),
    .DIV       (DIV),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observation counters, sampled on the falling edge
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         busy_cnt = 0;
  int         last_done_cyc = 0;
  int         last_busy_rise = 0;
  logic       busy_prev = 1'b0;
  logic       busy_at_done = 1'b0;
  logic [7:0] done_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_data.push_back(rx_data);
      last_done_cyc = cyc;
      busy_at_done = rx_busy;
    end
    if (frame_err) err_cnt++;
    if (rx_done && frame_err) both_cnt++;
    if (rx_busy) busy_cnt++;
    if (rx_busy && !busy_prev) last_busy_rise = cyc;
    busy_prev = rx_busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame, each bit held bl cycles; called on a falling edge
  task automatic send_frame(input logic [7:0] data, input logic stop, input int bl);
    uart_rxd = 1'b0;
    repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = data[i];
      repeat (bl) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (bl) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] div_port;
    int         bit_len;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, b0, t0;

    vecs[0] = '{8'hA5, 1'b1, 8'd10, 10, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 8'd10, 10, 1, 0, 8'h3C};
    vecs[2] = '{8'h81, 1'b0, 8'd10, 10, 0, 1, 8'h3C};  // stop low keeps old data
    vecs[3] = '{8'h55, 1'b1, 8'd10, 10, 1, 0, 8'h55};
    vecs[4] = '{8'h96, 1'b1, 8'd2,   4, 1, 0, 8'h96};  // DIV clamped to 4
    vecs[5] = '{8'h0F, 1'b1, 8'd7,   7, 1, 0, 8'h0F};  // odd divisor
    vecs[6] = '{8'h6B, 1'b0, 8'd4,   4, 0, 1, 8'h0F};
    vecs[7] = '{8'hE1, 1'b1, 8'd4,   4, 1, 0, 8'hE1};

    // Reset state
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    DIV      = 8'd10;
    repeat (4) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_done", rx_done, 0);
    check("reset frame_err", frame_err, 0);
    check("reset rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no start after reset release", busy_cnt, 0);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      d0  = done_cnt;
      e0  = err_cnt;
      DIV = vecs[v].div_port;
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].bit_len);
      uart_rxd = 1'b1;
      repeat (3 * vecs[v].bit_len) @(negedge clk);
      check($sformatf("vec%0d rx_done count", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("vec%0d frame_err count", v), err_cnt - e0, vecs[v].exp_err);
      check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_data);
    end

    // Exact latency and busy window, DIV=10
    DIV = 8'd10;
    d0  = done_cnt;
    b0  = busy_cnt;
    t0  = cyc;
    send_frame(8'h3C, 1'b1, 10);
    repeat (20) @(negedge clk);
    check("timing done count", done_cnt - d0, 1);
    check("timing busy rise", last_busy_rise - t0, SYNC + 1);
    check("timing done latency", last_done_cyc - last_busy_rise, 95);
    check("timing busy cycles", busy_cnt - b0, 95);
    check("timing busy low at done", busy_at_done, 0);
    check("timing data", rx_data, 8'h3C);

    // Glitch: 3-cycle low pulse is rejected at mid start bit
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch done", done_cnt - d0, 0);
    check("glitch err", err_cnt - e0, 0);
    check("glitch busy cycles", busy_cnt - b0, 5);
    check("glitch data", rx_data, 8'h3C);

    // Break: line held low after a bad stop bit must not start a new frame
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h00, 1'b0, 10);
    b0 = busy_cnt;
    repeat (300) @(negedge clk);
    check("break err", err_cnt - e0, 1);
    check("break idle while low", busy_cnt - b0, 0);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h55, 1'b1, 10);
    repeat (20) @(negedge clk);
    check("after break done", done_cnt - d0, 1);
    check("after break data", rx_data, 8'h55);

    // Back-to-back frames at DIV=16, no idle gap
    DIV = 8'd16;
    d0  = done_cnt;
    done_data.delete();
    send_frame(8'h00, 1'b1, 16);
    send_frame(8'hFF, 1'b1, 16);
    send_frame(8'h5A, 1'b1, 16);
    repeat (40) @(negedge clk);
    check("b2b done count", done_cnt - d0, 3);
    if (done_data.size() == 3) begin
      check("b2b data0", done_data[0], 8'h00);
      check("b2b data1", done_data[1], 8'hFF);
      check("b2b data2", done_data[2], 8'h5A);
    end else begin
      check("b2b data queue size", done_data.size(), 3);
    end

    // DIV change mid-frame has no effect
    DIV = 8'd10;
    d0  = done_cnt;
    fork
      send_frame(8'hE7, 1'b1, 10);
      begin
        repeat (30) @(negedge clk);
        DIV = 8'd20;
      end
    join
    repeat (20) @(negedge clk);
    check("div change done", done_cnt - d0, 1);
    check("div change data", rx_data, 8'hE7);
    DIV = 8'd10;

    // Reset during bit 4 aborts the frame silently
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      send_frame(8'hC3, 1'b1, 10);
      begin
        repeat (55) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset rx_data", rx_data, 8'h00);
        check("midreset rx_busy", rx_busy, 0);
        check("midreset rx_done", rx_done, 0);
        check("midreset frame_err", frame_err, 0);
      end
    join
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset no pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    send_frame(8'h12, 1'b1, 10);
    repeat (20) @(negedge clk);
    check("post reset done", done_cnt - d0, 1);
    check("post reset data", rx_data, 8'h12);

    check("done and err never together", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on uart_rxd (legal values 2..3).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 uart_rxd  input  1  asynchronous serial line; idle high; frame is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-005 DIV  input  8  clk cycles per bit; same encoding as the uart_tx DIV port.
REQ-006 rx_data  output  8  last correctly framed byte received.
REQ-007 rx_done  output  1  single-cycle pulse; rx_data is valid and newly updated.
REQ-008 frame_err  output  1  single-cycle pulse; stop bit was sampled low.
REQ-009 rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 uart_rxd SHALL pass through SYNC_STAGES flops; all logic below uses the synchronized value rxs plus a one-cycle-delayed copy rxs_d.
REQ-011 The block SHALL implement states IDLE, START, RECV and STOP.
REQ-012 IDLE: a start edge is rxs==0 && rxs_d==1; on that edge, go to START with count=0 and latch DIV into div_q.
REQ-013 div_q SHALL be max(DIV,4); DIV changes mid-frame SHALL have no effect.
REQ-014 START: count runs 0..div_q/2-1 (integer divide); at the last value, sample rxs; 0 -> RECV with count=0 and bit_cnt=0; 1 -> IDLE as a glitch, with no output pulse.
REQ-015 RECV: count runs 0..div_q-1; at div_q-1, shift rxs into shift_reg[bit_cnt] and increment bit_cnt; after bit_cnt 7 is sampled -> STOP with count=0.
REQ-016 STOP: at count==div_q-1, sample rxs; 1 -> rx_data<=shift_reg and rx_done=1 next cycle; 0 -> frame_err=1 next cycle and rx_data unchanged; either case -> IDLE.
REQ-017 rx_done and frame_err SHALL be registered, high exactly one cycle, and never high together.
REQ-018 Latency: if the start edge is detected in cycle E, rx_done/frame_err SHALL be high in cycle E + div_q/2 + 9*div_q + 1 (E+96 for DIV=10).
REQ-019 After a frame error with the line held low (break), no new frame SHALL start until rxs has returned high (the edge rule in REQ-012 enforces this).
REQ-020 A start edge arriving in the cycle IDLE is re-entered SHALL be accepted, so back-to-back frames need no idle gap.
REQ-021 count SHALL be 8 bits wide and never exceed div_q-1; bit_cnt SHALL be 3 bits and wrap 7->0 only on the RECV-to-STOP transition.

Reset
REQ-022 On rst_n low: state=IDLE, count=0, bit_cnt=0, shift_reg=0, rx_data=8'h00, rx_done=0, frame_err=0.
REQ-023 On rst_n low: synchronizer flops and rxs_d SHALL reset to 1, so release never produces a false start edge.
REQ-024 Reset mid-frame SHALL abort immediately; no pulse SHALL be emitted for the partial frame.

Structure
REQ-025 Shared package uart_pkg SHALL hold the state enum (IDLE, START, RECV, STOP) and the constant MIN_DIV=4; uart_tx SHALL be able to reuse both.
REQ-026 Sub-module uart_sync (a parameterized N-flop synchronizer with reset value 1) SHALL be instantiated once for uart_rxd.
REQ-027 No FIFO inside; the downstream consumer SHALL capture rx_data on rx_done.

Verification
REQ-028 Loopback: uart_tx into uart_rx, DIV=10, send 8'hA5 -> exactly one rx_done, rx_data==8'hA5, frame_err never high.
REQ-029 Timing: DIV=10, ideal frame 8'h3C -> rx_done exactly 96 cycles after start-edge detection; rx_busy high from E+1 through E+95.
REQ-030 Glitch: DIV=10, line low for 3 cycles, then high -> return to IDLE after START; no rx_done, no frame_err; rx_data unchanged.
REQ-031 Frame error: DIV=10, byte 8'h81 with stop bit 0, then line high -> frame_err pulse; rx_data keeps its prior value; next valid frame 8'h55 is received correctly.
REQ-032 Back-to-back: DIV=16, frames 8'h00, 8'hFF, 8'h5A with no idle gap -> three rx_done pulses, in order, with correct data.
REQ-033 Reset: assert rst_n during bit 4 of frame 8'hC3 -> all outputs at reset values; after release, the next frame 8'h12 is received correctly.
